// File: rtl/seq_mult_add.sv
// Shift-add multiply-accumulate: result = a*b + c, unsigned, one multiplier bit per ADD/SHIFT pair.
// Used to rebuild a dividend from quotient, divisor and remainder when self-checking the divider.
module seq_mult_add #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W:0]     c,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   result
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [2*W:0]    acc_reg;
  logic [2*W:0]    mcand_reg;
  logic [W-1:0]    mplier_reg;
  logic [CW-1:0]   count_reg;
  logic [2*W:0]    result_reg;
  logic            last_iter;

  assign last_iter = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (go) state_next = S_LOAD_WAIT;
      S_LOAD_WAIT: if (!go) state_next = S_ADD;
      S_ADD:       state_next = S_SHIFT;
      S_SHIFT:     state_next = last_iter ? S_DONE : S_ADD;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != S_IDLE);
    done = (state_reg == S_DONE);
  end

  // Operands are latched only on leaving IDLE, so later input changes cannot disturb a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (go) begin
            mcand_reg  <= {{(W+1){1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= {{W{1'b0}}, c};
            count_reg  <= '0;
          end
        end
        S_ADD: begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
        end
        S_SHIFT: begin
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          // acc already holds the final sum after the last ADD.
          if (last_iter) result_reg <= acc_reg;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule

// File: doc/seq_mult_add.md
Name: seq_mult_add

Overview:
Sequential shift-add multiply-accumulate unit computing result = a*b + c. It is the inverse of the team's restoring divider: fed quotient, divisor and remainder, it reconstructs the dividend, for on-board self-check of the divider. Structure is a control FSM plus datapath with a level go / one-cycle done handshake, driven from SW/KEY, with the result shown on LEDR/HEX.

Parameters:
W, 4, operand width of a and b; c is W+1 bits, result is 2W+1 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; returns block to S_IDLE
go  input  1  active-high start level; the top level inverts KEY[1]
a  input  W  multiplicand (e.g. quotient)
b  input  W  multiplier (e.g. divisor low bits)
c  input  W+1  addend (e.g. remainder)
busy  output  1  high whenever the state is not S_IDLE
done  output  1  high for exactly one cycle, in S_DONE
result  output  2W+1  registered a*b+c; holds until the next completion

Behaviour:
- Reset (synchronous, priority over all else):
  - state <= S_IDLE.
  - Internal regs zeroed: acc (2W+1), mcand (2W+1), mplier (W), count.
  - result <= 0; busy=0; done=0.
- S_IDLE:
  - go=0: stay.
  - go=1: capture mcand <= zero-extended a, mplier <= b, acc <= zero-extended c, count <= 0; go to S_LOAD_WAIT.
- S_LOAD_WAIT:
  - go=1: stay. Operands are NOT recaptured while waiting.
  - go=0: go to S_ADD.
- S_ADD: if mplier[0]=1, acc <= acc + mcand (2W+1-bit add); go to S_SHIFT.
- S_SHIFT:
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
  - If count == W-1 (last iteration): result <= acc, go to S_DONE; else go to S_ADD.
  - acc is final after the last S_ADD, so loading result from acc in the last S_SHIFT is correct.
- S_DONE: done=1 for one cycle; go to S_IDLE unconditionally. A go that is high in S_DONE is not sampled; it is sampled in the following S_IDLE cycle.
- Latency: if go is first sampled low in S_LOAD_WAIT at cycle k, S_ADD starts at k+1 and done=1 at cycle k+1+2W (k+9 for W=4). result is valid from that same cycle.
- Width rules:
  - The maximum value (2^W-1)^2 + 2^(W+1)-1 = 2^(2W) fits in 2W+1 bits, so no overflow is possible.
  - Unsigned arithmetic only.
  - mcand never loses bits: it shifts at most W-1 places into a 2W+1-bit register.
- busy is combinational from state (state != S_IDLE). done is combinational (state == S_DONE).
- go transitions while in S_ADD, S_SHIFT or S_DONE are ignored, and input changes after capture do not affect the running operation.
- Reset mid-operation: abort immediately. result is cleared to 0 and no done pulse occurs.
- b=0: acc is never added to, so result = c. a=0: result = c.
- count width is clog2(W)+1 bits, and it wraps only via reset/recapture.

Test Plan:
- W=4, a=7, b=2, c=1; pulse go 1 cycle -> done one cycle later at k+9; result=15 (0x00F); busy low the cycle after done.
- a=15, b=15, c=31 -> result=256 (0x100, top bit set); confirms 2W+1 width.
- a=9, b=0, c=5 -> result=5; a=0, b=11, c=0 -> result=0; result holds the value after done until the next run.
- Hold go high 20 cycles with a=3, b=5, c=2; change a to 8 while holding -> busy=1, no done during hold; done exactly 9 cycles after first go-low sample; result=17, built from the captured a=3.
- After a run with result=15: start a=6, b=6, c=0; assert reset at the 3rd S_ADD/S_SHIFT cycle -> next cycle busy=0, done=0, result=0; no done pulse follows; a new run afterwards gives 36.
- Round-trip against the divider: for all dividend 0..15 and divisor 1..15, feed quotient/divisor/remainder from the divider -> result equals dividend every time.
